sensor_drain_ctrl: RTL and testbench

Sequencer that owns the sensor controller's control inputs (`sctrl_en`, `sctrl_clear`, `sctrl_addr`) and moves each full sensor buffer to memory without CPU involvement.
- On a software start pulse it arms the sensor controller and waits for its buffer-full interrupt.
- It then reads every buffer word over `sctrl_addr`/`sctrl_out` and writes each word to a memory write port with a req/gnt handshake.
- Finally it clears the sensor controller and raises a done pulse.

It sits between the sensor controller and the memory-side write master, beside the AXI slave wrapper, which provides the configuration registers.

---
 rtl/sensor_drain_ctrl.sv | 124 ++++++++++++
 tb/tb_sensor_drain_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_drain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sensor_drain_ctrl                                          |
// | Description : Arms the sensor controller, then copies each full buffer   |
// |               to memory over a req/gnt write port. Continuous capture is |
// |               enabled by defining SENSOR_DRAIN_CONT_EN.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sensor_drain_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_start,
  input  logic          cfg_stop,
  input  logic [31:0]   cfg_base,
  input  logic          sctrl_interrupt,
  input  logic [31:0]   sctrl_out,
  output logic          sctrl_en,
  output logic          sctrl_clear,
  output logic [AW-1:0] sctrl_addr,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ARM   = 3'd1;
  localparam logic [2:0] c_READ  = 3'd2;
  localparam logic [2:0] c_WRITE = 3'd3;
  localparam logic [2:0] c_CLEAR = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);
`ifdef SENSOR_DRAIN_CONT_EN
  localparam logic [31:0] c_BLOCK_BYTES = 32'(DEPTH * 4);
`endif

  logic [2:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_base;
  logic [31:0]   r_data;
`ifdef SENSOR_DRAIN_CONT_EN
  logic          r_stop;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= c_IDLE;
      r_idx   <= '0;
      r_base  <= '0;
      r_data  <= '0;
`ifdef SENSOR_DRAIN_CONT_EN
      r_stop  <= 1'b0;
`endif
    end else begin
`ifdef SENSOR_DRAIN_CONT_EN
      // A stop outside ARM lets the current block finish, then ends the run.
      if (cfg_stop && r_state != c_IDLE && r_state != c_ARM)
        r_stop <= 1'b1;
`endif
      case (r_state)
        c_IDLE: begin
          if (cfg_start) begin
            r_base  <= {cfg_base[31:2], 2'b00};
            r_idx   <= '0;
            r_state <= c_ARM;
          end
        end
        c_ARM: begin
          if (cfg_stop)
            r_state <= c_IDLE;
          else if (sctrl_interrupt)
            r_state <= c_READ;
        end
        c_READ: begin
          r_data  <= sctrl_out;
          r_state <= c_WRITE;
        end
        c_WRITE: begin
          if (mem_gnt) begin
            if (r_idx == c_LAST_IDX) begin
              r_state <= c_CLEAR;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= c_READ;
            end
          end
        end
        c_CLEAR: r_state <= c_DONE;
        c_DONE: begin
`ifdef SENSOR_DRAIN_CONT_EN
          if (r_stop || cfg_stop) begin
            r_state <= c_IDLE;
            r_stop  <= 1'b0;
          end else begin
            r_state <= c_ARM;
            r_base  <= r_base + c_BLOCK_BYTES;
            r_idx   <= '0;
          end
`else
          r_state <= c_IDLE;
`endif
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != c_IDLE);
  assign sctrl_en    = (r_state == c_ARM);
  assign sctrl_clear = (r_state == c_CLEAR);
  assign sctrl_addr  = r_idx;
  assign mem_req     = (r_state == c_WRITE);
  assign mem_addr    = mem_req ? (r_base + 32'({r_idx, 2'b00})) : 32'd0;
  assign mem_wdata   = mem_req ? r_data : 32'd0;
  assign done        = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sensor_drain_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sensor_drain_ctrl                                       |
// | Description : Directed/randomized bench for sensor_drain_ctrl.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sensor_drain_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [31:0]   cfg_base = 32'd0;
  logic          sctrl_interrupt = 1'b0;
  logic          mem_gnt = 1'b0;
  logic [31:0]   sctrl_out;
  logic          sctrl_en, sctrl_clear, mem_req, busy, done;
  logic [AW-1:0] sctrl_addr;
  logic [31:0]   mem_addr, mem_wdata;

  logic [31:0]   sens [DEPTH];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  // Sensor buffer model: combinational read at the requested index.
  assign sctrl_out = sens[sctrl_addr];

  sensor_drain_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_base(cfg_base), .sctrl_interrupt(sctrl_interrupt), .sctrl_out(sctrl_out),
    .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear), .sctrl_addr(sctrl_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_en"}, sctrl_en, 1'b0);
    check1({tag, "_clear"}, sctrl_clear, 1'b0);
    check1({tag, "_req"}, mem_req, 1'b0);
    check1({tag, "_done"}, done, 1'b0);
    check32({tag, "_saddr"}, 32'(sctrl_addr), 32'd0);
    check32({tag, "_maddr"}, mem_addr, 32'd0);
    check32({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic fill_sens(input bit ramp);
    for (int i = 0; i < DEPTH; i++)
      sens[i] = ramp ? 32'(i) : $urandom;
  endtask

  task automatic start_block(input logic [31:0] base);
    cfg_base  = base;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_base  = $urandom;
    check1("start_en", sctrl_en, 1'b1);
    check1("start_busy", busy, 1'b1);
    check32("start_idx", 32'(sctrl_addr), 32'd0);
  endtask

  // Drains one block from ARM; expected addresses are base + 4*i, data sens[i].
  task automatic drain_block(input logic [31:0] exp_base, input int stall_word,
                             input int stall_len, input int abort_word,
                             input bit stop_mid, input bit keep_armed);
    int cyc;
    logic [31:0] exp_addr;
    repeat ($urandom_range(0, 3)) begin
      tick();
      check1("arm_hold_en", sctrl_en, 1'b1);
    end
    sctrl_interrupt = 1'b1;
    tick();
    sctrl_interrupt = 1'b0;
    check1("read_en_low", sctrl_en, 1'b0);
    check1("read_req_low", mem_req, 1'b0);
    cyc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr = exp_base + 32'(i) * 32'd4;
      check32("read_addr", 32'(sctrl_addr), 32'(i));
      mem_gnt = 1'($urandom);
      if (stop_mid && i == 5) cfg_stop = 1'b1;
      tick();
      cyc++;
      cfg_stop = 1'b0;
      check1("req", mem_req, 1'b1);
      check32("mem_addr", mem_addr, exp_addr);
      check32("mem_wdata", mem_wdata, sens[i]);
      if (i == abort_word) begin
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        mem_gnt = 1'b0;
        check_idle("abort");
        return;
      end
      if (i == stall_word) begin
        mem_gnt   = 1'b0;
        cfg_start = 1'b1;
        cfg_base  = $urandom;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          cyc++;
          check1("stall_req", mem_req, 1'b1);
          check32("stall_addr", mem_addr, exp_addr);
          check32("stall_wdata", mem_wdata, sens[i]);
        end
        cfg_start = 1'b0;
      end
      mem_gnt = 1'b1;
      tick();
      cyc++;
    end
    mem_gnt = 1'b0;
    check1("clear", sctrl_clear, 1'b1);
    check1("clear_en", sctrl_en, 1'b0);
    check32("block_cycles", 32'(cyc),
            32'(2 * DEPTH + ((stall_word >= 0) ? stall_len : 0)));
    tick();
    check1("done", done, 1'b1);
    check1("done_clear_low", sctrl_clear, 1'b0);
    tick();
    check1("done_pulse_end", done, 1'b0);
`ifdef SENSOR_DRAIN_CONT_EN
    if (stop_mid) begin
      check1("stop_idle", busy, 1'b0);
    end else begin
      check1("cont_rearm", sctrl_en, 1'b1);
      check32("cont_idx", 32'(sctrl_addr), 32'd0);
      if (!keep_armed) begin
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        check1("arm_stop_idle", busy, 1'b0);
      end
    end
`else
    check1("single_idle", busy, 1'b0);
    check1("single_en", sctrl_en, 1'b0);
    if (stop_mid || keep_armed) check1("single_no_cont", sctrl_en, 1'b0);
`endif
  endtask

  initial begin
    logic [31:0] b;
    fill_sens(1'b1);

    // Reset state, and interrupt ignored while idle.
    repeat (3) tick();
    check_idle("reset");
    rstn = 1'b1;
    sctrl_interrupt = 1'b1;
    mem_gnt = 1'b1;
    tick();
    sctrl_interrupt = 1'b0;
    mem_gnt = 1'b0;
    check_idle("idle_irq");

    // Basic ramp drain.
    start_block(32'h0001_0000);
    drain_block(32'h0001_0000, -1, 0, -1, 1'b0, 1'b0);

    // Backpressure on word 3 with a start pulse that must be ignored.
    fill_sens(1'b0);
    b = $urandom;
    start_block(b);
    drain_block({b[31:2], 2'b00}, 3, 5, -1, 1'b0, 1'b0);

    // Stop and interrupt in the same ARM cycle.
    start_block($urandom);
    sctrl_interrupt = 1'b1;
    cfg_stop = 1'b1;
    tick();
    sctrl_interrupt = 1'b0;
    cfg_stop = 1'b0;
    check1("race_busy", busy, 1'b0);
    check1("race_en", sctrl_en, 1'b0);
    repeat (4) begin
      tick();
      check1("race_no_write", mem_req, 1'b0);
    end

    // Reset during word 10, then a fresh block starting from index 0.
    fill_sens(1'b0);
    b = $urandom;
    start_block(b);
    drain_block({b[31:2], 2'b00}, -1, 0, 10, 1'b0, 1'b0);
    fill_sens(1'b0);
    b = $urandom;
    start_block(b);
    drain_block({b[31:2], 2'b00}, 20, 2, -1, 1'b0, 1'b0);

    // Misaligned base near the top of the address space.
    fill_sens(1'b0);
    start_block(32'hFFFF_FF03);
    drain_block(32'hFFFF_FF00, -1, 0, -1, 1'b0, 1'b1);
`ifdef SENSOR_DRAIN_CONT_EN
    fill_sens(1'b0);
    drain_block(32'hFFFF_FF00 + 32'(DEPTH * 4), 7, 3, -1, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
